// File: rtl/game_sequencer.sv
// game_sequencer: frame-rate game flow controller (title/play/hit/over), lives and
// survival score bookkeeping, round-robin enemy spawn scheduling and re-arm pulses.
module game_sequencer #(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned RESPAWN_FRAMES = 120,
  parameter int unsigned SPAWN_PERIOD   = 90,
  parameter int unsigned SCORE_DIV      = 60,
  parameter logic [7:0]  KEY_START      = 8'h28
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [23:0] keycode,
  input  logic        ball_die,
  input  logic [3:0]  enemy_alive,
  output logic        player_reset,
  output logic        enemy_clear,
  output logic        play_en,
  output logic        spawn_valid,
  output logic [1:0]  spawn_slot,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StHit  = 2'b10,
    StOver = 2'b11
  } state_e;

  localparam logic [9:0] ScoreLast   = 10'(SCORE_DIV - 1);
  localparam logic [9:0] SpawnLast   = 10'(SPAWN_PERIOD - 1);
  localparam logic [9:0] RespawnLast = 10'(RESPAWN_FRAMES - 1);
  localparam logic [2:0] LivesLoad   = 3'(LIVES_INIT);

  state_e      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [9:0]  score_tmr_q, score_tmr_d;
  logic [9:0]  spawn_tmr_q, spawn_tmr_d;
  logic [9:0]  resp_cnt_q, resp_cnt_d;
  logic [1:0]  rr_q, rr_d;
  logic        key_prev_q;
  logic        ignore_die_q, ignore_die_d;
  logic        player_reset_q, player_reset_d;
  logic        enemy_clear_q, enemy_clear_d;
  logic        spawn_valid_q, spawn_valid_d;
  logic [1:0]  spawn_slot_q, spawn_slot_d;

  logic        start_key;
  logic        start_edge;
  logic        free_found;
  logic [1:0]  free_slot;

  // Start key level from any of the three concurrent key bytes, and its rising edge.
  always_comb begin
    start_key  = (keycode[23:16] == KEY_START) || (keycode[15:8] == KEY_START) ||
                 (keycode[7:0] == KEY_START);
    start_edge = start_key && !key_prev_q;
  end

  // First free slot searching upward from the round-robin pointer, wrapping mod 4.
  always_comb begin
    logic [1:0] idx;
    free_found = 1'b0;
    free_slot  = rr_q;
    idx        = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (!free_found && !enemy_alive[idx]) begin
        free_found = 1'b1;
        free_slot  = idx;
      end
    end
  end

  // Next-state and next-output logic for the game flow.
  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    score_d        = score_q;
    score_tmr_d    = score_tmr_q;
    spawn_tmr_d    = spawn_tmr_q;
    resp_cnt_d     = resp_cnt_q;
    rr_d           = rr_q;
    ignore_die_d   = ignore_die_q;
    player_reset_d = 1'b0;
    enemy_clear_d  = 1'b0;
    spawn_valid_d  = 1'b0;
    spawn_slot_d   = spawn_slot_q;

    case (state_q)
      StIdle, StOver: begin
        if (start_edge) begin
          state_d        = StPlay;
          lives_d        = LivesLoad;
          score_d        = 16'd0;
          score_tmr_d    = 10'd0;
          spawn_tmr_d    = 10'd0;
          player_reset_d = 1'b1;
          enemy_clear_d  = 1'b1;
          // ball_die may still be high from the last game until player_reset lands.
          ignore_die_d   = 1'b1;
        end
      end
      StPlay: begin
        ignore_die_d = 1'b0;
        if (ball_die && !ignore_die_q) begin
          // Death wins over this frame's spawn and score activity; timers hold.
          state_d       = StHit;
          lives_d       = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          enemy_clear_d = 1'b1;
          resp_cnt_d    = RespawnLast;
        end else begin
          if (score_tmr_q >= ScoreLast) begin
            score_tmr_d = 10'd0;
            if (score_q != 16'hFFFF) begin
              score_d = score_q + 16'd1;
            end
          end else begin
            score_tmr_d = score_tmr_q + 10'd1;
          end
          if (spawn_tmr_q >= SpawnLast) begin
            spawn_tmr_d = 10'd0;
            // A full board drops the attempt and leaves the pointer where it was.
            if (free_found) begin
              spawn_valid_d = 1'b1;
              spawn_slot_d  = free_slot;
              rr_d          = free_slot + 2'd1;
            end
          end else begin
            spawn_tmr_d = spawn_tmr_q + 10'd1;
          end
        end
      end
      StHit: begin
        if (resp_cnt_q == 10'd0) begin
          if (lives_q == 3'd0) begin
            state_d = StOver;
          end else begin
            state_d        = StPlay;
            player_reset_d = 1'b1;
            spawn_tmr_d    = 10'd0;
            ignore_die_d   = 1'b1;
          end
        end else begin
          resp_cnt_d = resp_cnt_q - 10'd1;
        end
      end
      default: ;
    endcase
  end

  // State and counter registers; the key history resets high so a held key cannot start.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= StIdle;
      lives_q        <= 3'd0;
      score_q        <= 16'd0;
      score_tmr_q    <= 10'd0;
      spawn_tmr_q    <= 10'd0;
      resp_cnt_q     <= 10'd0;
      rr_q           <= 2'd0;
      key_prev_q     <= 1'b1;
      ignore_die_q   <= 1'b0;
      player_reset_q <= 1'b0;
      enemy_clear_q  <= 1'b0;
      spawn_valid_q  <= 1'b0;
      spawn_slot_q   <= 2'd0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      score_q        <= score_d;
      score_tmr_q    <= score_tmr_d;
      spawn_tmr_q    <= spawn_tmr_d;
      resp_cnt_q     <= resp_cnt_d;
      rr_q           <= rr_d;
      key_prev_q     <= start_key;
      ignore_die_q   <= ignore_die_d;
      player_reset_q <= player_reset_d;
      enemy_clear_q  <= enemy_clear_d;
      spawn_valid_q  <= spawn_valid_d;
      spawn_slot_q   <= spawn_slot_d;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    player_reset = player_reset_q;
    enemy_clear  = enemy_clear_q;
    play_en      = (state_q == StPlay);
    spawn_valid  = spawn_valid_q;
    spawn_slot   = spawn_slot_q;
    lives        = lives_q;
    score        = score_q;
    state        = state_q;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: start, spawn rotation, deaths, game over,
// restart, reset mid-HIT, and score saturation on a second fast-scoring instance.
module tb_game_sequencer;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [23:0] keycode;
  logic        ball_die;
  logic [3:0]  enemy_alive;
  logic        player_reset, enemy_clear, play_en, spawn_valid;
  logic [1:0]  spawn_slot;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [1:0]  state;

  logic        rst2;
  logic [23:0] key2;
  logic        die2;
  logic [3:0]  alive2;
  logic        pr2, ec2, pe2, sv2;
  logic [1:0]  ss2;
  logic [2:0]  lives2;
  logic [15:0] score2;
  logic [1:0]  state2;

  int checks = 0;
  int failures = 0;

  always #5 frame_clk = ~frame_clk;

  game_sequencer #(
    .LIVES_INIT(3), .RESPAWN_FRAMES(120), .SPAWN_PERIOD(4), .SCORE_DIV(5), .KEY_START(8'h28)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .ball_die(ball_die),
    .enemy_alive(enemy_alive), .player_reset(player_reset), .enemy_clear(enemy_clear),
    .play_en(play_en), .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .lives(lives),
    .score(score), .state(state)
  );

  game_sequencer #(
    .LIVES_INIT(3), .RESPAWN_FRAMES(120), .SPAWN_PERIOD(90), .SCORE_DIV(1), .KEY_START(8'h28)
  ) dut2 (
    .frame_clk(frame_clk), .Reset(rst2), .keycode(key2), .ball_die(die2),
    .enemy_alive(alive2), .player_reset(pr2), .enemy_clear(ec2), .play_en(pe2),
    .spawn_valid(sv2), .spawn_slot(ss2), .lives(lives2), .score(score2), .state(state2)
  );

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_lives"}, 32'(lives), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_play_en"}, 32'(play_en), 32'd0);
    chk({tag, "_player_reset"}, 32'(player_reset), 32'd0);
    chk({tag, "_enemy_clear"}, 32'(enemy_clear), 32'd0);
    chk({tag, "_spawn_valid"}, 32'(spawn_valid), 32'd0);
    chk({tag, "_spawn_slot"}, 32'(spawn_slot), 32'd0);
  endtask

  initial begin
    logic       exp_v;
    logic [1:0] exp_s;
    Reset = 1'b1; keycode = 24'd0; ball_die = 1'b0; enemy_alive = 4'b0000;
    rst2 = 1'b1; key2 = 24'd0; die2 = 1'b0; alive2 = 4'b0000;
    step(); step();
    chk_reset_vals("reset");

    Reset = 1'b0;
    step();
    chk("idle_after_release", 32'(state), 32'd0);

    // Start edge on the low byte.
    keycode = 24'h000028;
    step();
    chk("start_state", 32'(state), 32'd1);
    chk("start_lives", 32'(lives), 32'd3);
    chk("start_score", 32'(score), 32'd0);
    chk("start_player_reset", 32'(player_reset), 32'd1);
    chk("start_enemy_clear", 32'(enemy_clear), 32'd1);
    chk("start_play_en", 32'(play_en), 32'd1);

    // PLAY frames 1..20: key held through frame 10, spawns every 4th frame rotating slots.
    for (int k = 1; k <= 20; k++) begin
      if (k == 11) keycode = 24'd0;
      step();
      chk("held_no_player_reset", 32'(player_reset), 32'd0);
      chk("held_no_enemy_clear", 32'(enemy_clear), 32'd0);
      exp_v = (k % 4 == 0);
      chk("rot_spawn_valid", 32'(spawn_valid), 32'(exp_v));
      if (exp_v) chk("rot_spawn_slot", 32'(spawn_slot), 32'((k / 4 - 1) % 4));
    end
    chk("score_f20", 32'(score), 32'd4);

    // Frames 21..47: occupancy patterns exercise search order and full-board drop.
    for (int k = 21; k <= 47; k++) begin
      if (k >= 33 && k <= 36) enemy_alive = 4'b1011;
      else if (k >= 37 && k <= 40) enemy_alive = 4'b1111;
      else enemy_alive = 4'b0000;
      step();
      exp_v = (k % 4 == 0) && (k != 40);
      case (k)
        24: exp_s = 2'd1;
        28: exp_s = 2'd2;
        32: exp_s = 2'd3;
        36: exp_s = 2'd2;
        default: exp_s = 2'd3;
      endcase
      chk("occ_spawn_valid", 32'(spawn_valid), 32'(exp_v));
      if (exp_v) chk("occ_spawn_slot", 32'(spawn_slot), 32'(exp_s));
    end
    chk("score_f47", 32'(score), 32'd9);

    // Death on a frame that would also spawn: death wins.
    ball_die = 1'b1;
    step();
    chk("die1_state", 32'(state), 32'd2);
    chk("die1_lives", 32'(lives), 32'd2);
    chk("die1_enemy_clear", 32'(enemy_clear), 32'd1);
    chk("die1_play_en", 32'(play_en), 32'd0);
    chk("die1_no_spawn", 32'(spawn_valid), 32'd0);
    chk("die1_score", 32'(score), 32'd9);
    repeat (119) step();
    chk("hit1_still_hit", 32'(state), 32'd2);
    chk("hit1_no_player_reset", 32'(player_reset), 32'd0);
    step();
    chk("respawn1_state", 32'(state), 32'd1);
    chk("respawn1_player_reset", 32'(player_reset), 32'd1);
    chk("respawn1_play_en", 32'(play_en), 32'd1);
    step();
    chk("respawn1_die_ignored", 32'(state), 32'd1);
    chk("respawn1_pulse_done", 32'(player_reset), 32'd0);
    ball_die = 1'b0;
    step(); step();
    chk("score_resumed", 32'(score), 32'd10);
    step();
    chk("respawn_spawn_valid", 32'(spawn_valid), 32'd1);
    chk("respawn_spawn_slot", 32'(spawn_slot), 32'd0);

    // Second death, respawn, then third death while ball_die stays high.
    ball_die = 1'b1;
    step();
    chk("die2_state", 32'(state), 32'd2);
    chk("die2_lives", 32'(lives), 32'd1);
    repeat (119) step();
    step();
    chk("respawn2_state", 32'(state), 32'd1);
    chk("respawn2_player_reset", 32'(player_reset), 32'd1);
    step();
    chk("respawn2_die_ignored", 32'(state), 32'd1);
    step();
    chk("die3_state", 32'(state), 32'd2);
    chk("die3_lives", 32'(lives), 32'd0);
    chk("die3_enemy_clear", 32'(enemy_clear), 32'd1);
    repeat (119) step();
    step();
    chk("over_state", 32'(state), 32'd3);
    chk("over_lives", 32'(lives), 32'd0);
    chk("over_no_player_reset", 32'(player_reset), 32'd0);
    chk("over_no_enemy_clear", 32'(enemy_clear), 32'd0);
    chk("over_play_en", 32'(play_en), 32'd0);
    chk("over_score", 32'(score), 32'd10);
    repeat (5) step();
    chk("over_hold_state", 32'(state), 32'd3);
    chk("over_hold_score", 32'(score), 32'd10);

    // Restart from OVER with the key in the top byte.
    keycode = 24'h280000;
    step();
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_lives", 32'(lives), 32'd3);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_player_reset", 32'(player_reset), 32'd1);
    chk("restart_enemy_clear", 32'(enemy_clear), 32'd1);
    step();
    chk("restart_die_ignored", 32'(state), 32'd1);
    step();
    chk("die4_state", 32'(state), 32'd2);
    chk("die4_lives", 32'(lives), 32'd2);
    step(); step();

    // Asynchronous reset mid-HIT, key still held across it.
    Reset = 1'b1;
    #1;
    chk_reset_vals("midhit_reset");
    Reset = 1'b0;
    step();
    chk("post_reset_state", 32'(state), 32'd0);
    chk("post_reset_no_player_reset", 32'(player_reset), 32'd0);
    chk("post_reset_no_enemy_clear", 32'(enemy_clear), 32'd0);
    keycode = 24'd0;

    // Score saturation on the instance that scores every frame.
    rst2 = 1'b0;
    step();
    key2 = 24'h002800;
    step();
    chk("sat_start_state", 32'(state2), 32'd1);
    chk("sat_start_score", 32'(score2), 32'd0);
    repeat (65534) step();
    chk("sat_score_fffe", 32'(score2), 32'h0000FFFE);
    step();
    chk("sat_score_ffff", 32'(score2), 32'h0000FFFF);
    step();
    chk("sat_score_hold", 32'(score2), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Frame-rate controller that sequences the player ball and the four enemy slots. It runs the title/play/hit/game-over flow and owns the lives and survival-score counters. It schedules enemy spawns round-robin over free slots and generates the player-reset and enemy-clear pulses that re-arm the ball block after a death. It sits between the keycode source and the ball/enemy datapaths, and is clocked once per video frame.

Parameters:
LIVES_INIT, 3, lives loaded on game start (1..7)
RESPAWN_FRAMES, 120, frames frozen in HIT before respawn (1..1023)
SPAWN_PERIOD, 90, frames between spawn attempts in PLAY (1..1023)
SCORE_DIV, 60, frames per score increment in PLAY (1..1023)
KEY_START, 8'h28, keycode byte that starts/restarts a game (Enter)

Ports:
frame_clk  in  1  frame-rate clock, all state updates on rising edge
Reset  in  1  asynchronous, active-high; forces IDLE and all reset values
keycode  in  24  three concurrent key bytes [23:16],[15:8],[7:0]
ball_die  in  1  level from ball block; high once player is hit, held until player reset
enemy_alive  in  4  per-slot occupancy from enemy blocks
player_reset  out  1  one-frame pulse; clears ball position and ball_die
enemy_clear  out  1  one-frame pulse; kills all enemies
play_en  out  1  high only in PLAY; gates ball motion and enemy motion
spawn_valid  out  1  one-frame pulse requesting a spawn
spawn_slot  out  2  slot index qualified by spawn_valid
lives  out  3  remaining lives
score  out  16  survival score, saturating
state  out  2  00 IDLE, 01 PLAY, 10 HIT, 11 OVER

Behaviour:
- Reset values: state=IDLE, lives=0, score=0, play_en=0, player_reset=0, enemy_clear=0, spawn_valid=0, spawn_slot=0. Internal counters and rr pointer are 0.
- start_key = KEY_START matches any of the three keycode bytes. It is edge-detected: the previous-frame value is registered, and only a 0->1 transition counts. A key held across reset or across the OVER transition does not retrigger.
- IDLE/OVER -> PLAY on start_key edge. The same edge loads lives=LIVES_INIT, clears score, spawn timer and score timer, and asserts player_reset and enemy_clear for that one frame.
- PLAY: play_en=1.
  - Score timer counts 0..SCORE_DIV-1. On wrap, score+1, saturating at 16'hFFFF.
  - Spawn timer counts 0..SPAWN_PERIOD-1. On wrap, spawn is attempted.
- Spawn scheduling: search from rr pointer upward, mod 4, for the first slot with enemy_alive=0.
  - If found, spawn_valid=1 and spawn_slot=that index for exactly one frame; rr = index+1 (mod 4).
  - If all four slots are alive, no pulse, and rr is unchanged. The attempt is dropped, not queued.
  - At most one spawn per frame.
- PLAY -> HIT when ball_die=1, sampled at the frame edge. The same frame:
  - lives decrements by 1;
  - enemy_clear pulses;
  - play_en falls;
  - the respawn counter loads RESPAWN_FRAMES-1;
  - any spawn wrap in that frame is suppressed.
  ball_die takes priority over spawn and score.
- HIT: the counter decrements each frame. At 0:
  - if lives=0, go to OVER and assert no pulses;
  - otherwise go to PLAY, asserting player_reset on the transition frame; the spawn timer restarts at 0 and the score timer retains its value.
- While in HIT, ball_die is ignored because it stays high until player_reset. The post-respawn PLAY frame ignores ball_die for 1 frame, covering the player_reset latency.
- OVER: play_en=0. score and lives=0 are held for display until start_key.
- start_key has no effect in PLAY or HIT.
- All pulse outputs are registered and are high for exactly one frame_clk cycle.
- Reset asserted mid-HIT or mid-PLAY returns immediately to IDLE with reset values. No pulses are emitted on reset release.
- Counter widths are 10 bits. Parameters of 1 mean a wrap every frame.

Test Plan:
- Reset, then keycode=24'h000028 for 1 frame -> next edge: state=01, lives=3, score=0, player_reset=1 and enemy_clear=1 for one frame; holding the key 10 frames causes no further pulses.
- PLAY with enemy_alive=4'b0000, SPAWN_PERIOD=4 -> spawn_valid on frames 4,8,12,16 with slots 0,1,2,3, then 0.
- enemy_alive=4'b1011, rr=0 -> spawn_slot=2, rr becomes 3. enemy_alive=4'b1111 -> no spawn_valid, rr unchanged.
- Assert ball_die in PLAY with lives=3 -> same frame: state=10, lives=2, enemy_clear=1, play_en=0. After RESPAWN_FRAMES=120 frames: state=01 and player_reset=1. Drop ball_die afterwards -> PLAY continues.
- Three deaths -> after the third HIT expires, state=11 and lives=0, with no player_reset; score is held. A start_key edge then restarts with lives=3 and score=0.
- Force score to 16'hFFFE with SCORE_DIV=1 -> score reaches 16'hFFFF and saturates. Assert Reset mid-HIT -> all outputs take reset values immediately.
